// File: rtl/pam_n_slicer.sv
// PAM-2/4/8 threshold slicer with a two-stage valid/ready pipeline.
// Stage 1 registers the sample and its decided level index; stage 2
// registers the mapped symbol, the saturated slicer error and the clip flag.
// Saturating handshake counters provide simple link statistics.
module pam_n_slicer #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int SYM_CNT_W         = 32,
  parameter int CLIP_CNT_W        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_in,
  input  logic                                voltage_level_in_valid,
  output logic                                voltage_level_in_ready,
  input  logic [1:0]                          mode,
  input  logic                                gray_en,
  input  logic                                cnt_clr,
  output logic [2:0]                          symbol_out,
  output logic                                symbol_out_valid,
  input  logic                                symbol_out_ready,
  output logic signed [SIGNAL_RESOLUTION:0]   slicer_err,
  output logic                                clip_flag,
  output logic [SYM_CNT_W-1:0]                sym_count,
  output logic [CLIP_CNT_W-1:0]               clip_count
);
  localparam int SR   = SIGNAL_RESOLUTION;
  localparam int W    = SR + 3;
  localparam int HALF = SYMBOL_SEPERATION / 2;
  localparam logic signed [W-1:0] HALF_W  = W'(HALF);
  localparam logic signed [W-1:0] ERR_MAX = W'((1 << SR) - 1);
  localparam logic signed [W-1:0] ERR_MIN = W'(-(1 << SR));

  // Pipeline and counter state
  logic                 s1_valid_q, s1_valid_d;
  logic signed [SR-1:0] s1_x_q, s1_x_d;
  logic [2:0]           s1_idx_q, s1_idx_d;
  logic [1:0]           s1_mode_q, s1_mode_d;
  logic                 s1_gray_q, s1_gray_d;
  logic                 out_valid_q, out_valid_d;
  logic [2:0]           sym_q, sym_d;
  logic signed [SR:0]   err_q, err_d;
  logic                 clip_q, clip_d;
  logic [SYM_CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [CLIP_CNT_W-1:0] clip_cnt_q, clip_cnt_d;

  logic                advance;
  logic                handshake;
  logic signed [W-1:0] x_ext;
  logic [6:0]          ge;
  logic [2:0]          idx_in;
  logic [2:0]          sym_calc;
  logic signed [W-1:0] err_calc;
  logic                clip_calc;

  assign advance   = !out_valid_q || symbol_out_ready;
  assign handshake = out_valid_q && symbol_out_ready;
  assign x_ext     = W'(voltage_level_in);

  // One comparator bank on the PAM-8 grid (-3S..+3S in steps of S).
  // PAM-4 uses its middle three thresholds, PAM-2 only the zero threshold.
  for (genvar gi = 0; gi < 7; gi++) begin : g_thr
    localparam logic signed [W-1:0] THR = W'((2 * (gi + 1) - 8) * HALF);
    assign ge[gi] = (x_ext >= THR);
  end

  // Level index = number of active thresholds passed for the chosen mode
  always_comb begin
    case (mode)
      2'd0:    idx_in = {2'b00, ge[3]};
      2'd2:    idx_in = 3'($countones(ge));
      default: idx_in = 3'($countones(ge[4:2]));
    endcase
  end

  // Stage-2 math: ideal level, saturated error, clip detect and mapping
  always_comb begin
    int                  m_minus1;
    logic signed [W-1:0] level;
    logic signed [W-1:0] err_abs;
    case (s1_mode_q)
      2'd0:    m_minus1 = 1;
      2'd2:    m_minus1 = 7;
      default: m_minus1 = 3;
    endcase
    level    = W'((2 * int'(s1_idx_q) - m_minus1) * HALF);
    err_calc = W'(s1_x_q) - level;
    err_abs  = err_calc[W-1] ? -err_calc : err_calc;
    // Clip uses the unsaturated error so a saturated value is still flagged
    clip_calc = (err_abs > HALF_W);
    sym_calc  = s1_gray_q ? (s1_idx_q ^ (s1_idx_q >> 1)) : s1_idx_q;
    if (err_calc > ERR_MAX) begin
      err_d = {1'b0, {SR{1'b1}}};
    end else if (err_calc < ERR_MIN) begin
      err_d = {1'b1, {SR{1'b0}}};
    end else begin
      err_d = err_calc[SR:0];
    end
    if (!advance) begin
      err_d = err_q;
    end
  end

  // Both stages move together on advance, otherwise everything holds
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_idx_d    = s1_idx_q;
    s1_mode_d   = s1_mode_q;
    s1_gray_d   = s1_gray_q;
    out_valid_d = out_valid_q;
    sym_d       = sym_q;
    clip_d      = clip_q;
    if (advance) begin
      s1_valid_d  = voltage_level_in_valid;
      s1_x_d      = voltage_level_in;
      s1_idx_d    = idx_in;
      s1_mode_d   = mode;
      s1_gray_d   = gray_en;
      out_valid_d = s1_valid_q;
      sym_d       = sym_calc;
      clip_d      = clip_calc;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_comb begin
    sym_cnt_d  = sym_cnt_q;
    clip_cnt_d = clip_cnt_q;
    if (cnt_clr) begin
      sym_cnt_d  = '0;
      clip_cnt_d = '0;
    end else if (handshake) begin
      if (sym_cnt_q != '1) begin
        sym_cnt_d = sym_cnt_q + 1'b1;
      end
      if (clip_q && (clip_cnt_q != '1)) begin
        clip_cnt_d = clip_cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear of data path and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_idx_q    <= '0;
      s1_mode_q   <= '0;
      s1_gray_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sym_q       <= '0;
      err_q       <= '0;
      clip_q      <= 1'b0;
      sym_cnt_q   <= '0;
      clip_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_idx_q    <= s1_idx_d;
      s1_mode_q   <= s1_mode_d;
      s1_gray_q   <= s1_gray_d;
      out_valid_q <= out_valid_d;
      sym_q       <= sym_d;
      err_q       <= err_d;
      clip_q      <= clip_d;
      sym_cnt_q   <= sym_cnt_d;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  assign voltage_level_in_ready = advance;
  assign symbol_out             = sym_q;
  assign symbol_out_valid       = out_valid_q;
  assign slicer_err             = err_q;
  assign clip_flag              = clip_q;
  assign sym_count              = sym_cnt_q;
  assign clip_count             = clip_cnt_q;

endmodule

// File: tb/tb_pam_n_slicer.sv
// Directed bench for pam_n_slicer. Instance A uses SEP=56 (PAM-2/4) with a
// 4-bit symbol counter so saturation is reachable; instance B uses SEP=32
// so PAM-8 levels fit the 8-bit range. Expected results are queued when a
// sample is accepted and compared when the DUT hands the output over.
module tb_pam_n_slicer;
  localparam int SR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [SR-1:0] din = '0;
  logic vld_a = 1'b0, vld_b = 1'b0;
  logic rdy_a, rdy_b;
  logic [1:0] mode = 2'd1;
  logic gray = 1'b0, clr = 1'b0, out_ready = 1'b1;
  logic [2:0] sym_a, sym_b;
  logic ov_a, ov_b;
  logic signed [SR:0] err_a, err_b;
  logic clip_a, clip_b;
  logic [3:0]  scnt_a;
  logic [15:0] ccnt_a;
  logic [31:0] scnt_b;
  logic [15:0] ccnt_b;

  always #5 clk = ~clk;

  pam_n_slicer #(.SIGNAL_RESOLUTION(SR), .SYMBOL_SEPERATION(56),
                 .SYM_CNT_W(4), .CLIP_CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .voltage_level_in(din),
    .voltage_level_in_valid(vld_a), .voltage_level_in_ready(rdy_a),
    .mode(mode), .gray_en(gray), .cnt_clr(clr),
    .symbol_out(sym_a), .symbol_out_valid(ov_a), .symbol_out_ready(out_ready),
    .slicer_err(err_a), .clip_flag(clip_a),
    .sym_count(scnt_a), .clip_count(ccnt_a));

  pam_n_slicer #(.SIGNAL_RESOLUTION(SR), .SYMBOL_SEPERATION(32),
                 .SYM_CNT_W(32), .CLIP_CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .voltage_level_in(din),
    .voltage_level_in_valid(vld_b), .voltage_level_in_ready(rdy_b),
    .mode(mode), .gray_en(gray), .cnt_clr(clr),
    .symbol_out(sym_b), .symbol_out_valid(ov_b), .symbol_out_ready(out_ready),
    .slicer_err(err_b), .clip_flag(clip_b),
    .sym_count(scnt_b), .clip_count(ccnt_b));

  typedef struct {
    logic [2:0] sym;
    int         err;
    logic       clip;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit bp_en  = 1'b0;
  int bp_ph  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; optionally step the
  // downstream ready pattern 1,0,0,1,0,0,...
  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) begin
      bp_ph     = (bp_ph + 1) % 3;
      out_ready = (bp_ph == 0);
    end
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  // Present one sample to instance b (0=A, 1=B) and queue its expectation
  task automatic send(bit b, int x, logic [1:0] m, logic g,
                      logic [2:0] es, int ee, logic ec, bit lat);
    exp_t e;
    int n;
    din  = SR'(x);
    mode = m;
    gray = g;
    vld_a = !b;
    vld_b = b;
    n = 0;
    @(negedge clk);
    while (!(b ? rdy_b : rdy_a) && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", n, 0);
    e.sym = es; e.err = ee; e.clip = ec; e.cyc = cyc; e.lat = lat;
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
    tick();
    vld_a = 1'b0;
    vld_b = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", q_a.size() + q_b.size(), 0);
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic mon_pop(bit b, logic [2:0] s, logic signed [SR:0] e, logic c);
    exp_t x;
    if ((b ? q_b.size() : q_a.size()) == 0) begin
      chk(b ? "unexpected_out_b" : "unexpected_out_a", 1, 0);
    end else begin
      x = b ? q_b.pop_front() : q_a.pop_front();
      $display("out %s sym=%0d err=%0d clip=%0d (exp %0d %0d %0d)",
               b ? "B" : "A", s, e, c, x.sym, x.err, x.clip);
      chk(b ? "sym_b" : "sym_a", s, x.sym);
      chk(b ? "err_b" : "err_a", e, x.err);
      chk(b ? "clip_b" : "clip_a", c, x.clip);
      if (x.lat) chk("latency", cyc - x.cyc, 2);
    end
  endtask

  // Output monitor: scoreboard pops, stall hold and stall ready checks
  logic [2:0]         hold_sym;
  logic signed [SR:0] hold_err;
  logic               hold_clip;
  logic               hold_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_stall <= 1'b0;
    end else begin
      if (hold_stall) begin
        chk("hold_valid", ov_a, 1);
        chk("hold_sym", sym_a, hold_sym);
        chk("hold_err", err_a, hold_err);
        chk("hold_clip", clip_a, hold_clip);
      end
      if (ov_a && !out_ready) chk("stall_in_ready", rdy_a, 0);
      if (ov_a && out_ready) mon_pop(1'b0, sym_a, err_a, clip_a);
      if (ov_b && out_ready) mon_pop(1'b1, sym_b, err_b, clip_b);
      hold_stall <= ov_a && !out_ready;
      hold_sym   <= sym_a;
      hold_err   <= err_a;
      hold_clip  <= clip_a;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    rst = 1'b0;
    #1;
    chk("rst_valid", ov_a, 0);
    chk("rst_sym", sym_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_clip", clip_a, 0);
    chk("rst_scnt", scnt_a, 0);
    chk("rst_ccnt", ccnt_a, 0);
    chk("rst_in_ready", rdy_a, 1);
    tick();

    // PAM-4 binary, back-to-back; -56 sits on a threshold -> upper level
    send(0, 30,   2'd1, 0, 3'd2,   2, 0, 1);
    send(0, -100, 2'd1, 0, 3'd0, -16, 0, 1);
    send(0, 0,    2'd1, 0, 3'd2, -28, 0, 1);
    send(0, -56,  2'd1, 0, 3'd1, -28, 0, 1);
    drain();
    chk("pam4_scnt", scnt_a, 4);
    chk("pam4_ccnt", ccnt_a, 0);

    // PAM-4 Gray, clipped outer sample, reserved mode acts as PAM-4
    send(0, 90,   2'd1, 1, 3'd2,   6, 0, 1);
    send(0, -127, 2'd1, 1, 3'd0, -43, 1, 1);
    send(0, -28,  2'd3, 0, 3'd1,   0, 0, 1);
    drain();
    chk("gray_scnt", scnt_a, 7);
    chk("gray_ccnt", ccnt_a, 1);

    // cnt_clr on the same cycle as a clipped handshake
    send(0, -127, 2'd1, 0, 3'd0, -43, 1, 0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_scnt", scnt_a, 0);
    chk("clr_ccnt", ccnt_a, 0);
    send(0, 127, 2'd1, 0, 3'd3, 43, 1, 1);
    drain();
    chk("after_clr_scnt", scnt_a, 1);
    chk("after_clr_ccnt", ccnt_a, 1);

    // PAM-8 on SEP=32, then PAM-2 on the very next sample
    send(1, -128, 2'd2, 0, 3'd0, -16, 0, 1);
    send(1, -33,  2'd2, 0, 3'd2,  15, 0, 1);
    send(1, 31,   2'd2, 0, 3'd4,  15, 0, 1);
    send(1, 127,  2'd2, 0, 3'd7,  15, 0, 1);
    send(1, -1,   2'd0, 0, 3'd0,  15, 0, 1);
    send(1, 127,  2'd2, 1, 3'd4,  15, 0, 1);
    drain();
    chk("pam8_scnt", scnt_b, 6);
    chk("pam8_ccnt", ccnt_b, 0);

    // Backpressure: ready pattern 1,0,0 while streaming six samples
    clear_counts();
    bp_en = 1'b1;
    bp_ph = 0;
    out_ready = 1'b1;
    send(0, 84,  2'd1, 0, 3'd3,   0, 0, 0);
    send(0, -84, 2'd1, 0, 3'd0,   0, 0, 0);
    send(0, 28,  2'd1, 0, 3'd2,   0, 0, 0);
    send(0, -28, 2'd1, 0, 3'd1,   0, 0, 0);
    send(0, 60,  2'd1, 0, 3'd3, -24, 0, 0);
    send(0, -10, 2'd1, 0, 3'd1,  18, 0, 0);
    drain();
    bp_en = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk("bp_scnt", scnt_a, 6);

    // Asynchronous reset with two samples in flight
    send(0, 10,  2'd1, 0, 3'd2, -18, 0, 0);
    send(0, -10, 2'd1, 0, 3'd1,  18, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", ov_a, 0);
    chk("arst_sym", sym_a, 0);
    chk("arst_err", err_a, 0);
    chk("arst_scnt", scnt_a, 0);
    chk("arst_in_ready", rdy_a, 1);
    q_a.delete();
    tick();
    #2;
    rst = 1'b0;
    tick();
    send(0, 28, 2'd1, 0, 3'd2, 0, 0, 1);
    drain();
    chk("post_rst_scnt", scnt_a, 1);

    // Symbol counter saturates at all-ones (4-bit on instance A)
    clear_counts();
    repeat (15) send(0, 0, 2'd1, 0, 3'd2, -28, 0, 0);
    drain();
    chk("sat_reach", scnt_a, 15);
    repeat (3) send(0, 0, 2'd1, 0, 3'd2, -28, 0, 0);
    drain();
    chk("sat_hold", scnt_a, 15);
    chk("sat_ccnt", ccnt_a, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
